// File: rtl/edgeconv_pixel_tx.sv
// -----------------------------------------------------------------------------
// edgeconv_pixel_tx
//
// Frame-buffered pixel transmitter that feeds edgeconv_top.
//
// Flow:
//   1. The host fills a 28x28 8-bit frame over a byte valid/ready handshake.
//   2. A start pulse replays the frame as one unbroken pix_valid/pix_data
//      burst of NPIX beats. The first beat appears two cycles after start:
//      one cycle for the synchronous buffer read and one for the output
//      register.
//   3. The block then waits for the classifier result. When res_valid
//      arrives it captures res_digit and pulses done.
//   4. If no result arrives within TIMEOUT cycles of the last pixel, digit
//      is set to all-ones and done and timeout_err pulse together.
//
// The frame buffer is written only while loading and read only while
// streaming, so a single simple dual-port RAM is sufficient.
// -----------------------------------------------------------------------------
module edgeconv_pixel_tx #(
    parameter int NPIX    = 784,   // pixels per frame (buffer depth)
    parameter int DW      = 8,     // pixel width
    parameter int DIGIT_W = 4,     // classifier result width
    parameter int TIMEOUT = 4096   // max cycles from last pixel to result
) (
    input  logic               clk,
    input  logic               rst,          // synchronous, active-high

    // Host load port
    input  logic               ld_valid,
    input  logic [DW-1:0]      ld_data,
    output logic               ld_ready,

    // Host control
    input  logic               start,

    // Pixel stream towards edgeconv_top
    output logic               pix_valid,
    output logic [DW-1:0]      pix_data,

    // Result from edgeconv_top
    input  logic               res_valid,
    input  logic [DIGIT_W-1:0] res_digit,

    // Host status
    output logic               busy,
    output logic               done,
    output logic [DIGIT_W-1:0] digit,
    output logic               timeout_err
);

    // -------------------------------------------------------------------------
    // Local sizing
    // -------------------------------------------------------------------------
    localparam int PTR_W  = $clog2(NPIX);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NPIX - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Controller state
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,      // empty buffer, waiting for the first byte
        S_LOAD,      // partial frame held
        S_FULL,      // full frame held, waiting for start
        S_STREAM,    // replaying the frame to the classifier
        S_WAIT_RES,  // stream finished, waiting for the classifier result
        S_DONE       // one-cycle result presentation
    } state_t;

    state_t state;

    // Load-side write pointer
    logic [PTR_W-1:0]  wr_ptr;

    // Stream-side read pointer; it points at the next buffer address to issue
    logic [PTR_W-1:0]  rd_ptr;

    // Elapsed cycles since the last pixel while waiting for the result
    logic [TCNT_W-1:0] tcnt;

    // Frame buffer and its registered read port
    logic [DW-1:0]     frame_mem [NPIX];
    logic [DW-1:0]     rd_data;

    // rd_data holds a freshly issued pixel
    logic              rd_vld;

    // Decoded events
    logic              ld_accept;    // host byte taken this cycle
    logic              rd_issue;     // a buffer read is launched this cycle
    logic              last_pix;     // output register holds the final pixel
    logic              timeout_hit;  // this wait cycle is the last one allowed

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------

    // A byte is accepted only while ld_ready is high.
    assign ld_accept   = ld_valid && ld_ready;

    // Address 0 is issued in the start cycle itself, which keeps the
    // start-to-first-pixel latency at two cycles. After that, one address is
    // issued per cycle until rd_ptr wraps back to zero.
    assign rd_issue    = ((state == S_FULL) && start) ||
                         ((state == S_STREAM) && (rd_ptr != '0));

    // The final beat is on the output while nothing is left in the read
    // stage.
    assign last_pix    = (state == S_STREAM) && pix_valid && !rd_vld;

    // tcnt reads k in the k-th cycle after the last pixel. Deciding when
    // tcnt is TIMEOUT-1 therefore places done exactly TIMEOUT cycles after
    // the last pixel.
    assign timeout_hit = (tcnt == TCNT_LAST);

    // -------------------------------------------------------------------------
    // Frame buffer: one write port for loading, one registered read port
    // for streaming.
    // -------------------------------------------------------------------------
    // NOTE: the buffer is deliberately left out of reset so it maps onto
    // block RAM. Its contents are only ever read after a complete load.
    always_ff @(posedge clk) begin
        if (ld_accept && !rst)
            frame_mem[wr_ptr] <= ld_data;
        rd_data <= frame_mem[rd_ptr];
    end

    // -------------------------------------------------------------------------
    // Read pipeline: issue addresses, then register the pixel onto the
    // output. pix_data is forced to zero between bursts.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            rd_vld    <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            rd_vld    <= rd_issue;
            if (rd_issue)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            pix_valid <= rd_vld;
            pix_data  <= rd_vld ? rd_data : '0;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered host-side outputs.
    // -------------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment, so all
    // decisions in a cycle see the pre-edge values of state, counters and
    // outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            tcnt        <= '0;
            ld_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            digit       <= '0;
        end else begin
            // done and timeout_err are single-cycle pulses by default
            done        <= 1'b0;
            timeout_err <= 1'b0;

            unique case (state)
                S_IDLE, S_LOAD: begin
                    if (ld_accept) begin
                        if (wr_ptr == LAST_PTR) begin
                            // Frame complete: close the load port.
                            wr_ptr   <= '0;
                            ld_ready <= 1'b0;
                            state    <= S_FULL;
                        end else begin
                            wr_ptr   <= wr_ptr + PTR_W'(1);
                            state    <= S_LOAD;
                        end
                    end
                end

                S_FULL: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (last_pix) begin
                        // The next cycle is the first one counted while
                        // waiting for the result.
                        tcnt  <= TCNT_W'(1);
                        state <= S_WAIT_RES;
                    end
                end

                S_WAIT_RES: begin
                    if (res_valid) begin
                        // A real result wins even on the timeout cycle.
                        digit <= res_digit;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        tcnt  <= '0;
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        digit       <= '1;
                        done        <= 1'b1;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        tcnt        <= '0;
                        state       <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end

                S_DONE: begin
                    // The buffer keeps its data, but a fresh frame must be
                    // loaded before the next start is honoured.
                    ld_ready <= 1'b1;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edgeconv_pixel_tx.sv
// -----------------------------------------------------------------------------
// tb_edgeconv_pixel_tx
//
// Randomized self-checking bench for edgeconv_pixel_tx.
//
// The reference model tracks each transaction as a timeline:
//   - bytes accepted into the current frame,
//   - the cycle in which start was honoured,
//   - the cycle in which done is due.
// From these it derives, on every cycle, what the outputs must show:
//   - pixel k is due at start + 2 + k,
//   - the last pixel is at start + 1 + NPIX,
//   - done follows the first result after the last pixel, or arrives
//     TIMEOUT cycles after the last pixel.
// A few literal expectations pin the model itself.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_edgeconv_pixel_tx;

    localparam int NPIX    = 784;
    localparam int DW      = 8;
    localparam int DIGIT_W = 4;
    localparam int TIMEOUT = 4096;

    // -------------------------------------------------------------------------
    // DUT connections and clock
    // -------------------------------------------------------------------------
    logic               clk = 1'b0;
    logic               rst;
    logic               ld_valid;
    logic [DW-1:0]      ld_data;
    logic               ld_ready;
    logic               start;
    logic               pix_valid;
    logic [DW-1:0]      pix_data;
    logic               res_valid;
    logic [DIGIT_W-1:0] res_digit;
    logic               busy;
    logic               done;
    logic [DIGIT_W-1:0] digit;
    logic               timeout_err;

    edgeconv_pixel_tx #(
        .NPIX    (NPIX),
        .DW      (DW),
        .DIGIT_W (DIGIT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .start       (start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .res_valid   (res_valid),
        .res_digit   (res_digit),
        .busy        (busy),
        .done        (done),
        .digit       (digit),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;      // index of the current clock cycle
    bit chk_en = 1'b0;  // cycle-by-cycle checking is on once reset is seen

    // Reference model state
    logic [DW-1:0]      m_frame [NPIX];
    int                 m_loaded   = 0;   // bytes accepted into the current frame
    int                 m_s        = -1;  // cycle in which start was honoured
    int                 m_done_cyc = -1;  // cycle in which done is due
    logic [DIGIT_W-1:0] m_digit    = '0;
    bit                 m_terr     = 1'b0;

    // Observations of the DUT, used only for literal checks
    int   st_cyc    = 0;
    int   obs_first = -1;
    int   obs_last  = -1;
    int   obs_cnt   = 0;
    int   obs_sum   = 0;
    int   obs_done  = -1;
    logic obs_terr  = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: consumes the inputs sampled at each rising edge and
    // updates the transaction timeline for the cycle that follows.
    // -------------------------------------------------------------------------
    always @(posedge clk) begin : model
        int c;
        int last;
        c = cyc;
        if (rst === 1'b1) begin
            m_loaded   = 0;
            m_s        = -1;
            m_done_cyc = -1;
            m_digit    = '0;
            m_terr     = 1'b0;
            chk_en     = 1'b1;
        end else if (m_s >= 0 && m_done_cyc == c) begin
            // The done cycle ends the transaction; loading is open again
            // on the following cycle.
            m_s        = -1;
            m_done_cyc = -1;
            m_loaded   = 0;
            m_terr     = 1'b0;
        end else if (m_s < 0) begin
            if (m_loaded < NPIX) begin
                // Still loading: start is ignored, bytes are accepted.
                if (ld_valid === 1'b1) begin
                    m_frame[m_loaded] = ld_data;
                    m_loaded++;
                end
            end else if (start === 1'b1) begin
                m_s = c;
            end
        end else if (m_done_cyc < 0) begin
            last = m_s + 1 + NPIX;
            if (c > last && res_valid === 1'b1) begin
                // A result arriving after the last pixel is accepted.
                m_done_cyc = c + 1;
                m_digit    = res_digit;
                m_terr     = 1'b0;
            end else if (c == last + TIMEOUT - 1) begin
                // No result in time: report a timeout.
                m_done_cyc = c + 1;
                m_digit    = '1;
                m_terr     = 1'b1;
            end
        end
        cyc = c + 1;
    end

    // -------------------------------------------------------------------------
    // Compare process: on every cycle after reset, check all outputs against
    // the model on the falling edge.
    // -------------------------------------------------------------------------
    always @(negedge clk) begin : compare
        int            k;
        logic          e_pv;
        logic [DW-1:0] e_pd;
        logic          e_busy;
        logic          e_done;
        logic          e_ready;
        if (chk_en) begin
            e_pv = 1'b0;
            e_pd = '0;
            if (m_s >= 0) begin
                k = cyc - m_s - 2;
                if (k >= 0 && k < NPIX) begin
                    e_pv = 1'b1;
                    e_pd = m_frame[k];
                end
            end
            e_busy  = (m_s >= 0) && (cyc > m_s) &&
                      (m_done_cyc < 0 || cyc < m_done_cyc);
            e_done  = (m_done_cyc == cyc);
            e_ready = (m_s < 0) && (m_loaded < NPIX);

            check("pix_valid",   32'(pix_valid),   32'(e_pv));
            check("pix_data",    32'(pix_data),    32'(e_pd));
            check("busy",        32'(busy),        32'(e_busy));
            check("done",        32'(done),        32'(e_done));
            check("timeout_err", 32'(timeout_err), 32'(e_done && m_terr));
            check("ld_ready",    32'(ld_ready),    32'(e_ready));
            check("digit",       32'(digit),       32'(m_digit));

            if (pix_valid === 1'b1) begin
                if (obs_cnt == 0)
                    obs_first = cyc;
                obs_last = cyc;
                obs_cnt++;
                obs_sum += int'(pix_data);
            end
            if (done === 1'b1) begin
                obs_done = cyc;
                obs_terr = timeout_err;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one frame.
    //   kind:       0 = ramp i%256, 1 = constant 8'hAA, 2 = random
    //   gap:        0 = back-to-back, 1 = toggled 1-0, 2 = random gaps
    //   spur_start: byte index at which a start is also asserted (-1 none)
    task automatic load_frame(input int kind, input int gap,
                              input int spur_start);
        for (int i = 0; i < NPIX; i++) begin
            int guard;
            guard    = 0;
            ld_valid = 1'b1;
            ld_data  = (kind == 0) ? DW'(i % 256) :
                       (kind == 1) ? 8'hAA : DW'($urandom);
            start    = (i == spur_start);
            while (ld_ready !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20) begin
                check("ld_ready_wait", 32'(ld_ready), 32'd1);
                ld_valid = 1'b0;
                start    = 1'b0;
                return;
            end
            tick();
            start    = 1'b0;
            ld_valid = 1'b0;
            if (i == NPIX - 1)
                check("ld_ready_after_full", 32'(ld_ready), 32'd0);
            if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0))
                tick();
        end
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        st_cyc   = cyc;
        obs_cnt  = 0;
        obs_sum  = 0;
        obs_done = -1;
        tick();
        start    = 1'b0;
    endtask

    // Drive res_valid in the cycle `delay` cycles after the expected last
    // pixel (delay 0 is the last pixel cycle itself).
    task automatic send_result(input int delay, input logic [DIGIT_W-1:0] d);
        int tgt;
        tgt = st_cyc + 1 + NPIX + delay;
        while (cyc < tgt)
            tick();
        res_valid = 1'b1;
        res_digit = d;
        tick();
        res_valid = 1'b0;
        res_digit = DIGIT_W'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        tick();
        check({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    // Literal expectations for a stream that completed normally.
    task automatic check_stream(input string name);
        check({name, "_first_latency"}, 32'(obs_first - st_cyc), 32'd2);
        check({name, "_beats"},         32'(obs_cnt), 32'd784);
        check({name, "_contiguous"},    32'(obs_last - obs_first + 1), 32'd784);
    endtask

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d",
                 cyc);
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_data   = '0;
        start     = 1'b0;
        res_valid = 1'b0;
        res_digit = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset values
        check("rst_ld_ready",  32'(ld_ready),    32'd1);
        check("rst_pix_valid", 32'(pix_valid),   32'd0);
        check("rst_pix_data",  32'(pix_data),    32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_done",      32'(done),        32'd0);
        check("rst_terr",      32'(timeout_err), 32'd0);
        check("rst_digit",     32'(digit),       32'd0);

        // Ramp load, result digit 7
        load_frame(0, 0, -1);
        repeat (2) tick();
        pulse_start();
        send_result(5, 4'd7);
        wait_done("ramp", 10);
        check_stream("ramp");
        check("ramp_sum",   32'(obs_sum),  32'd98040);
        check("ramp_digit", 32'(digit),    32'd7);
        check("ramp_terr",  32'(obs_terr), 32'd0);

        // Throttled load (valid toggled 1-0), random result
        load_frame(0, 1, -1);
        pulse_start();
        send_result($urandom_range(1, 40), DIGIT_W'($urandom));
        wait_done("throttle", 10);
        check_stream("throttle");
        check("throttle_sum", 32'(obs_sum), 32'd98040);

        // Timeout: no result ever
        load_frame(2, 0, -1);
        pulse_start();
        wait_done("timeout", NPIX + TIMEOUT + 20);
        check_stream("timeout");
        check("timeout_delay", 32'(obs_done - obs_last), 32'd4096);
        check("timeout_digit", 32'(digit),    32'hF);
        check("timeout_terr",  32'(obs_terr), 32'd1);

        // Spurious start during load and spurious result during stream
        load_frame(2, 2, 500);
        pulse_start();
        while (cyc < st_cyc + 100)
            tick();
        res_valid = 1'b1;
        res_digit = 4'd9;
        tick();
        res_valid = 1'b0;
        send_result(0, 4'd12);  // lands on the last pixel: still ignored
        send_result(3, 4'd3);
        wait_done("spurious", 10);
        check_stream("spurious");
        check("spurious_digit", 32'(digit), 32'd3);

        // Mid-stream reset at pixel 300, then a fresh frame
        load_frame(2, 0, -1);
        pulse_start();
        while (cyc < st_cyc + 2 + 300)
            tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_pix_valid", 32'(pix_valid), 32'd0);
        check("midrst_ld_ready",  32'(ld_ready),  32'd1);
        check("midrst_busy",      32'(busy),      32'd0);
        load_frame(2, 2, -1);
        pulse_start();
        send_result($urandom_range(1, 60), 4'd4);
        wait_done("midrst", 10);
        check_stream("midrst");
        check("midrst_digit", 32'(digit), 32'd4);

        // Back-to-back: constant 8'hAA frame loaded right after done
        load_frame(1, 0, -1);
        pulse_start();
        send_result(2, 4'd5);
        wait_done("aa", 10);
        check_stream("aa");
        check("aa_sum",   32'(obs_sum), 32'd133280);
        check("aa_digit", 32'(digit),   32'd5);

        // Result in the very cycle the timeout would fire: the result wins
        load_frame(2, 0, -1);
        pulse_start();
        send_result(TIMEOUT - 1, 4'd6);
        wait_done("tie", 10);
        check("tie_delay", 32'(obs_done - obs_last), 32'd4096);
        check("tie_digit", 32'(digit),    32'd6);
        check("tie_terr",  32'(obs_terr), 32'd0);

        // Random frames with random gaps and result delays
        for (int f = 0; f < 2; f++) begin
            load_frame(2, 2, -1);
            repeat ($urandom_range(0, 5)) tick();
            pulse_start();
            send_result($urandom_range(1, 60), DIGIT_W'($urandom));
            wait_done("random", 10);
            check_stream("random");
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
